arp_resolver: RTL

Address-resolution engine answering IP-to-MAC requests from the IPv4 transmit path. It resolves each request from a small fully associative cache or by emitting ARP request frames, with timeout and retry. Replies are consumed from the ARP frame receiver. It sits between the IP block's ARP request/response port and the ARP frame tx/rx blocks.

---
 rtl/arp_resolver_if.sv | 31 +++
 rtl/arp_resolver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_resolver_if.sv
// Handshake bundle between the ARP resolver, the IP block's ARP port and the ARP frame tx/rx blocks.
// The slave modport is the resolver's view; master is the view of the logic around it.
interface arp_resolver_if;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        m_arp_req_valid;
    logic        m_arp_req_ready;
    logic [31:0] m_arp_req_tpa;
    logic        s_arp_reply_valid;
    logic [31:0] s_arp_reply_spa;
    logic [47:0] s_arp_reply_sha;

    modport slave (
        input  arp_request_valid, arp_request_ip, arp_response_ready,
        input  m_arp_req_ready, s_arp_reply_valid, s_arp_reply_spa, s_arp_reply_sha,
        output arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        output m_arp_req_valid, m_arp_req_tpa
    );

    modport master (
        output arp_request_valid, arp_request_ip, arp_response_ready,
        output m_arp_req_ready, s_arp_reply_valid, s_arp_reply_spa, s_arp_reply_sha,
        input  arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        input  m_arp_req_valid, m_arp_req_tpa
    );
endinterface

// File: rtl/arp_resolver.sv
// IPv4-to-MAC resolver: small fully associative cache in front of ARP request/reply frames,
// with per-attempt timeout and bounded retry. All outputs are registered.
module arp_resolver #(
    parameter int CACHE_ENTRIES       = 4,
    parameter int REQUEST_TIMEOUT     = 125000000,
    parameter int REQUEST_RETRY_COUNT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    arp_resolver_if.slave bus,
    input  logic          clear_cache,
    input  logic [31:0]   local_ip,
    input  logic [31:0]   gateway_ip,
    input  logic [31:0]   subnet_mask
);

    localparam int IDX_W     = $clog2(CACHE_ENTRIES);
    localparam int TIMER_W   = $clog2(REQUEST_TIMEOUT);
    localparam int ATTEMPT_W = $clog2(REQUEST_RETRY_COUNT + 1);

    localparam logic [TIMER_W-1:0]   TIMER_LOAD  = TIMER_W'(REQUEST_TIMEOUT - 1);
    localparam logic [ATTEMPT_W-1:0] ATTEMPT_MAX = ATTEMPT_W'(REQUEST_RETRY_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SEND_REQ,
        ST_WAIT_REPLY,
        ST_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic                 lookup_stage_q, lookup_stage_d;
    logic                 bcast_q, bcast_d;
    logic [31:0]          target_q, target_d;
    logic                 hit_q, hit_d;
    logic [47:0]          hit_mac_q, hit_mac_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ATTEMPT_W-1:0] attempt_q, attempt_d;

    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_error_q, resp_error_d;
    logic [47:0]          resp_mac_q, resp_mac_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [31:0]          frame_tpa_q, frame_tpa_d;

    logic [CACHE_ENTRIES-1:0] cache_valid_q, cache_valid_d;
    logic [IDX_W-1:0]         cache_ptr_q, cache_ptr_d;
    logic [31:0]              cache_ip_q  [CACHE_ENTRIES];
    logic [47:0]              cache_mac_q [CACHE_ENTRIES];

    logic        req_is_bcast;
    logic [31:0] req_target;
    logic        reply_match;
    logic        lookup_hit;
    logic [47:0] lookup_mac;
    logic        upd_hit;
    logic [IDX_W-1:0] upd_idx;
    logic        cache_write;
    logic [IDX_W-1:0] write_idx;

    // Off-subnet destinations are resolved through the gateway.
    assign req_is_bcast = (bus.arp_request_ip == 32'hFFFF_FFFF) ||
                          (bus.arp_request_ip == (local_ip | ~subnet_mask));
    assign req_target   = (((bus.arp_request_ip ^ local_ip) & subnet_mask) == 32'd0) ?
                          bus.arp_request_ip : gateway_ip;
    assign reply_match  = bus.s_arp_reply_valid && (bus.s_arp_reply_spa == target_q);

    // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
    // only the clocked blocks use '<='.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_mac = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (!lookup_hit && cache_valid_q[i] && (cache_ip_q[i] == target_q)) begin
                lookup_hit = 1'b1;
                lookup_mac = cache_mac_q[i];
            end
        end
    end

    // A reply for an address already cached refreshes it in place instead of taking a new slot.
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (!upd_hit && cache_valid_q[i] && (cache_ip_q[i] == bus.s_arp_reply_spa)) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cache_write   = bus.s_arp_reply_valid && (bus.s_arp_reply_spa != 32'd0) && !clear_cache;
        write_idx     = upd_hit ? upd_idx : cache_ptr_q;
        cache_valid_d = cache_valid_q;
        cache_ptr_d   = cache_ptr_q;
        if (clear_cache) begin
            cache_valid_d = '0;
            cache_ptr_d   = '0;
        end else if (cache_write) begin
            cache_valid_d[write_idx] = 1'b1;
            if (!upd_hit) begin
                cache_ptr_d = cache_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: every signal gets its hold value before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        lookup_stage_d = lookup_stage_q;
        bcast_d        = bcast_q;
        target_d       = target_q;
        hit_d          = hit_q;
        hit_mac_d      = hit_mac_q;
        timer_d        = timer_q;
        attempt_d      = attempt_q;
        resp_error_d   = resp_error_q;
        resp_mac_d     = resp_mac_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.arp_request_valid && req_ready_q) begin
                    target_d       = req_target;
                    bcast_d        = req_is_bcast;
                    lookup_stage_d = 1'b0;
                    hit_d          = 1'b0;
                    state_d        = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // First cycle registers the associative compare, second cycle acts on it.
                if (!lookup_stage_q) begin
                    if (bcast_q) begin
                        resp_error_d = 1'b0;
                        resp_mac_d   = '1;
                        state_d      = ST_RESPOND;
                    end else begin
                        lookup_stage_d = 1'b1;
                        hit_d          = lookup_hit || reply_match;
                        hit_mac_d      = reply_match ? bus.s_arp_reply_sha : lookup_mac;
                    end
                end else if (reply_match) begin
                    resp_error_d = 1'b0;
                    resp_mac_d   = bus.s_arp_reply_sha;
                    state_d      = ST_RESPOND;
                end else if (hit_q) begin
                    resp_error_d = 1'b0;
                    resp_mac_d   = hit_mac_q;
                    state_d      = ST_RESPOND;
                end else begin
                    attempt_d = ATTEMPT_W'(1);
                    state_d   = ST_SEND_REQ;
                end
            end
            ST_SEND_REQ: begin
                if (bus.m_arp_req_ready) begin
                    timer_d = TIMER_LOAD;
                    state_d = ST_WAIT_REPLY;
                end
            end
            ST_WAIT_REPLY: begin
                if (reply_match) begin
                    resp_error_d = 1'b0;
                    resp_mac_d   = bus.s_arp_reply_sha;
                    state_d      = ST_RESPOND;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (attempt_q < ATTEMPT_MAX) begin
                    attempt_d = attempt_q + 1'b1;
                    state_d   = ST_SEND_REQ;
                end else begin
                    resp_error_d = 1'b1;
                    resp_mac_d   = '0;
                    state_d      = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (bus.arp_response_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d   = (state_d == ST_IDLE);
        resp_valid_d  = (state_d == ST_RESPOND);
        frame_valid_d = (state_d == ST_SEND_REQ);
        frame_tpa_d   = (state_d == ST_SEND_REQ) ? target_q : frame_tpa_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            lookup_stage_q <= 1'b0;
            bcast_q        <= 1'b0;
            target_q       <= '0;
            hit_q          <= 1'b0;
            hit_mac_q      <= '0;
            timer_q        <= '0;
            attempt_q      <= '0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_mac_q     <= '0;
            frame_valid_q  <= 1'b0;
            frame_tpa_q    <= '0;
            cache_valid_q  <= '0;
            cache_ptr_q    <= '0;
        end else begin
            state_q        <= state_d;
            lookup_stage_q <= lookup_stage_d;
            bcast_q        <= bcast_d;
            target_q       <= target_d;
            hit_q          <= hit_d;
            hit_mac_q      <= hit_mac_d;
            timer_q        <= timer_d;
            attempt_q      <= attempt_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_error_q   <= resp_error_d;
            resp_mac_q     <= resp_mac_d;
            frame_valid_q  <= frame_valid_d;
            frame_tpa_q    <= frame_tpa_d;
            cache_valid_q  <= cache_valid_d;
            cache_ptr_q    <= cache_ptr_d;
        end
    end

    // NOTE: the cache payload is deliberately left without reset; an entry is only ever
    // read through its valid bit, which is reset above.
    always_ff @(posedge clk) begin
        if (cache_write) begin
            cache_ip_q[write_idx]  <= bus.s_arp_reply_spa;
            cache_mac_q[write_idx] <= bus.s_arp_reply_sha;
        end
    end

    assign bus.arp_request_ready  = req_ready_q;
    assign bus.arp_response_valid = resp_valid_q;
    assign bus.arp_response_error = resp_error_q;
    assign bus.arp_response_mac   = resp_mac_q;
    assign bus.m_arp_req_valid    = frame_valid_q;
    assign bus.m_arp_req_tpa      = frame_tpa_q;

endmodule
